// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers:
// per-boundary payload widths, control-field bit positions and the
// occupancy encoding used by the skid-buffered stage.
package pipe_pkg;

  // Payload widths for each stage boundary of the core.
  localparam int IFID_DATA_W  = 96;   // IR, PC, PC+4
  localparam int IFID_CTRL_W  = 4;
  localparam int IDEX_DATA_W  = 128;  // operands, immediate, PC+4
  localparam int IDEX_CTRL_W  = 16;
  localparam int EXMEM_DATA_W = 104;  // ALU result, store data, rd
  localparam int EXMEM_CTRL_W = 8;
  localparam int MEMWB_DATA_W = 72;   // load/ALU result, rd
  localparam int MEMWB_CTRL_W = 4;

  // Control-vector bit positions used when packing/unpacking ctrl words.
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_JUMP       = 5;
  localparam int CTRL_ALU_SRC    = 6;
  localparam int CTRL_ALU_OP_LSB = 7;
  localparam int CTRL_ALU_OP_W   = 4;
  localparam int CTRL_USED_W     = CTRL_ALU_OP_LSB + CTRL_ALU_OP_W;

  // Occupancy of a skid-buffered stage, encoded as {skid_valid, main_valid}.
  // The skid slot is only ever filled while main is valid, so 2'b10 is unused.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload slot: valid bit plus data and control registers.
// Priority: flush > load > drop. Control is zeroed whenever the slot
// goes invalid so an empty slot never presents live control bits.
module pipe_skid_slot #(
  parameter int DATA_W   = 128,
  parameter int CTRL_W   = 16,
  parameter int CLR_DATA = 1
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              load,
  input  logic              drop,
  input  logic              flush,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  // Slot state update: reset, flush, load or drop.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the data register is reset too; it is a single word, not a
      // memory array, and downstream expects all-zero outputs after reset.
      valid  <= 1'b0;
      q_ctrl <= '0;
      q_data <= '0;
    end else if (flush) begin
      // NOTE: non-blocking assignments throughout, so every register in
      // the stage samples pre-edge values regardless of statement order.
      valid  <= 1'b0;
      q_ctrl <= '0;
      if (CLR_DATA != 0) q_data <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      q_data <= d_data;
      q_ctrl <= d_ctrl;
    end else if (drop) begin
      valid  <= 1'b0;
      q_ctrl <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage carrying one data+control payload with a
// valid/ready handshake, flush, optional 2-entry skid buffer and a
// saturating stall counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int CTRL_W   = 16,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 1,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              accept;
  logic              emit;
  logic              main_load;
  logic              main_drop;
  logic              main_from_skid;
  logic              skid_load;
  logic              skid_drop;
  logic [DATA_W-1:0] main_d_data;
  logic [CTRL_W-1:0] main_d_ctrl;
  stage_state_e      state;

  assign out_valid = main_valid;
  assign accept    = in_valid & in_ready;
  assign emit      = main_valid & out_ready;
  assign state     = stage_state_e'({skid_valid, main_valid});

  // Slot control: which slot loads, drops or refills from the skid slot.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    main_load      = 1'b0;
    main_drop      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    if (SKID == 0) begin
      main_load = accept;
      main_drop = emit & ~accept;
    end else begin
      case (state)
        ST_EMPTY: main_load = accept;
        ST_ONE: begin
          if (accept && emit) main_load = 1'b1;
          else if (accept)    skid_load = 1'b1;
          else if (emit)      main_drop = 1'b1;
        end
        ST_FULL: begin
          if (emit) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_drop      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign main_d_data = main_from_skid ? skid_data : in_data;
  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_skid_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CLR_DATA (CLR_DATA)
  ) u_main (
    .CLK     (CLK),
    .reset_n (reset_n),
    .load    (main_load),
    .drop    (main_drop),
    .flush   (flush),
    .d_data  (main_d_data),
    .d_ctrl  (main_d_ctrl),
    .valid   (main_valid),
    .q_data  (out_data),
    .q_ctrl  (out_ctrl)
  );

  if (SKID != 0) begin : g_skid
    // in_ready comes straight from a flop, cutting the downstream ready path.
    assign in_ready = ~skid_valid;

    pipe_skid_slot #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CLR_DATA (CLR_DATA)
    ) u_skid (
      .CLK     (CLK),
      .reset_n (reset_n),
      .load    (skid_load),
      .drop    (skid_drop),
      .flush   (flush),
      .d_data  (in_data),
      .d_ctrl  (in_ctrl),
      .valid   (skid_valid),
      .q_data  (skid_data),
      .q_ctrl  (skid_ctrl)
    );
  end else begin : g_no_skid
    assign in_ready   = ~main_valid | out_ready;
    assign skid_valid = 1'b0;
    assign skid_data  = '0;
    assign skid_ctrl  = '0;
  end

  // Saturating count of cycles where downstream refused a valid payload.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && !flush && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule
